// File: rtl/spi_slave_core_if.sv
// Parallel-side bus of the SPI target engine: TX word supply and RX word delivery.
// valid/ready: a word moves only in a cycle where both are high; tx_ready is a one-cycle capture pulse.
interface spi_slave_core_if #(
   parameter int C_DATA_WIDTH = 8
);
   logic [C_DATA_WIDTH-1:0] tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic [C_DATA_WIDTH-1:0] rx_data;
   logic                    rx_valid;
   logic                    rx_ready;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid
   );
endinterface

// File: rtl/spi_slave_core.sv
// SPI target serial engine: oversamples SCK/CS_n/MOSI in sysclk, all CPOL/CPHA modes.
// Optional macro SPI_SLAVE_LSB_FIRST_EN adds the lsb_first port (bit order select).
module spi_slave_core #(
   parameter int C_DATA_WIDTH = 8
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       enable,
   input  logic       CPOL,
   input  logic       CPHA,
   input  logic       sck,
   input  logic       cs_n,
   input  logic       mosi,
`ifdef SPI_SLAVE_LSB_FIRST_EN
   input  logic       lsb_first,
`endif
   output logic       miso,
   output logic       miso_oe,
   output logic       busy,
   output logic       overrun,
   output logic       underrun,
   output logic [0:0] dbg_state,
   spi_slave_core_if.slave bus
);

   localparam int W     = C_DATA_WIDTH;
   localparam int CNT_W = $clog2(W);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic sck_s1_q, sck_s2_q, sck_s3_q;
   logic cs_s1_q, cs_s2_q;
   logic mosi_s1_q, mosi_s2_q;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [W-1:0]     tx_shift_q, tx_shift_d;
   logic [W-1:0]     rx_shift_q, rx_shift_d;
   logic [W-1:0]     rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             miso_q, miso_d;
   logic             tx_ready_q, tx_ready_d;
   logic             underrun_q, underrun_d;
   logic             overrun_q, overrun_d;

   logic         lsb_mode;
   logic         sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic         load_word, pre_shift;
   logic [W-1:0] loaded;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign lsb_mode = lsb_first;
`else
   assign lsb_mode = 1'b0;
`endif

   assign sck_rise    = sck_s2_q & ~sck_s3_q;
   assign sck_fall    = ~sck_s2_q & sck_s3_q;
   assign lead_edge   = CPOL ? sck_fall : sck_rise;
   assign trail_edge  = CPOL ? sck_rise : sck_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      miso_d     = miso_q;
      tx_ready_d = 1'b0;
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
      load_word  = 1'b0;
      pre_shift  = 1'b0;
      loaded     = '0;

      if (rx_valid_q && bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            miso_d = 1'b0;
            if (!cs_s2_q && enable) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = '0;
               load_word = 1'b1;
               pre_shift = ~CPHA;
            end
         end
         default: begin
            // CS rise or disable outranks any edge decoded in the same cycle.
            if (cs_s2_q || !enable) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = '0;
               miso_d     = 1'b0;
               tx_shift_d = '0;
            end else if (sample_edge) begin
               rx_shift_d = lsb_mode ? {mosi_s2_q, rx_shift_q[W-1:1]}
                                     : {rx_shift_q[W-2:0], mosi_s2_q};
               if (bit_cnt_q == CNT_W'(W-1)) begin
                  bit_cnt_d  = '0;
                  rx_data_d  = rx_shift_d;
                  rx_valid_d = 1'b1;
                  overrun_d  = rx_valid_q & ~bus.rx_ready;
                  load_word  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (shift_edge) begin
               miso_d     = lsb_mode ? tx_shift_q[0] : tx_shift_q[W-1];
               tx_shift_d = lsb_mode ? (tx_shift_q >> 1) : (tx_shift_q << 1);
            end
         end
      endcase

      if (load_word) begin
         if (bus.tx_valid) begin
            loaded     = bus.tx_data;
            tx_ready_d = 1'b1;
         end else begin
            underrun_d = 1'b1;
         end
         tx_shift_d = loaded;
         // CPHA=0 needs the first bit on the pin before the first leading edge.
         if (pre_shift) begin
            miso_d     = lsb_mode ? loaded[0] : loaded[W-1];
            tx_shift_d = lsb_mode ? (loaded >> 1) : (loaded << 1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         sck_s1_q   <= 1'b0;
         sck_s2_q   <= 1'b0;
         sck_s3_q   <= 1'b0;
         cs_s1_q    <= 1'b1;
         cs_s2_q    <= 1'b1;
         mosi_s1_q  <= 1'b0;
         mosi_s2_q  <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sck_s1_q   <= sck;
         sck_s2_q   <= sck_s1_q;
         sck_s3_q   <= sck_s2_q;
         cs_s1_q    <= cs_n;
         cs_s2_q    <= cs_s1_q;
         mosi_s1_q  <= mosi;
         mosi_s2_q  <= mosi_s1_q;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         tx_ready_q <= tx_ready_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   assign miso         = miso_q;
   assign miso_oe      = (state_q == ST_ACTIVE);
   assign busy         = (state_q == ST_ACTIVE);
   assign overrun      = overrun_q;
   assign underrun     = underrun_q;
   assign dbg_state    = state_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: behavioural SPI master, TX feeder, RX scoreboard, random transfers.
module tb_spi_slave_core;
  localparam int W = 8;

  logic       sysclk = 1'b0;
  logic       rst, enable, cpol, cpha, sck, cs_n, mosi;
  logic       miso, miso_oe, busy, overrun, underrun;
  logic [0:0] dbg_state;
  logic       lsb_mode = 1'b0;

  spi_slave_core_if #(.C_DATA_WIDTH(W)) bus ();

  spi_slave_core #(.C_DATA_WIDTH(W)) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .enable    (enable),
    .CPOL      (cpol),
    .CPHA      (cpha),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .lsb_first (lsb_mode),
`endif
    .miso      (miso),
    .miso_oe   (miso_oe),
    .busy      (busy),
    .overrun   (overrun),
    .underrun  (underrun),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // clock / reset
  always #5 sysclk = ~sysclk;

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_got_q[$];
  logic [W-1:0] tx_words_q[$];
  logic [W-1:0] mosi_words_q[$];
  logic [W-1:0] miso_words_q[$];
  logic [W-1:0] tx_mem [256];
  int tx_lim = 0;
  int tx_ptr = 0;
  int cnt_txr = 0;
  int cnt_und = 0;
  int cnt_ovr = 0;
  logic busy_before, busy_after, oe_after;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // monitor: pulse counters and accepted RX words
  initial begin
    forever begin
      @(negedge sysclk);
      if (bus.tx_ready) cnt_txr++;
      if (underrun) cnt_und++;
      if (overrun) cnt_ovr++;
      if (bus.rx_valid && bus.rx_ready) rx_got_q.push_back(bus.rx_data);
    end
  end

  // TX feeder: presents tx_mem[tx_ptr] while words remain, advances on tx_ready
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    forever begin
      @(negedge sysclk);
      if (bus.tx_ready) tx_ptr++;
      if (tx_ptr < tx_lim) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = tx_mem[tx_ptr];
      end else begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
      end
    end
  end

  // SPI master driver: SCK half period = 4 sysclk
  task automatic spi_xfer(input logic pol, input logic pha, input int nbits);
    logic b_q[$];
    logic [W-1:0] acc;
    acc = '0;
    foreach (mosi_words_q[wi])
      for (int k = 0; k < W; k++)
        b_q.push_back(lsb_mode ? mosi_words_q[wi][k] : mosi_words_q[wi][W-1-k]);
    while (b_q.size() < nbits) b_q.push_back(1'b0);
    miso_words_q.delete();
    @(negedge sysclk);
    cpol = pol; cpha = pha; sck = pol; mosi = 1'b0;
    wait_cyc(8);
    cs_n = 1'b0;
    if (!pha) mosi = b_q[0];
    wait_cyc(4);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        acc = {acc[W-2:0], miso};
        sck = ~pol;
        wait_cyc(4);
        sck = pol;
        if (i + 1 < nbits) mosi = b_q[i+1];
        wait_cyc(4);
      end else begin
        sck = ~pol;
        mosi = b_q[i];
        wait_cyc(4);
        acc = {acc[W-2:0], miso};
        sck = pol;
        wait_cyc(4);
      end
      if (i % W == W - 1) miso_words_q.push_back(acc);
    end
    busy_before = busy;
    cs_n = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    busy_after = busy;
    oe_after   = miso_oe;
    wait_cyc(8);
  endtask

  // one transfer checked against the word-level model
  task automatic run_xfer(input string tag, input logic pol, input logic pha,
                          input int nbits, input logic rdy);
    int n_full, cons, k, b_txr, b_und, b_ovr, rx_base, exp_txr, exp_ovr;
    logic prior_valid;
    logic [W-1:0] e;
    n_full = nbits / W;
    cons   = 1 + n_full;
    k      = tx_words_q.size();
    foreach (tx_words_q[i]) tx_mem[tx_lim + i] = tx_words_q[i];
    tx_lim = tx_lim + k;
    bus.rx_ready = rdy;
    wait_cyc(4);
    prior_valid = bus.rx_valid;
    b_txr = cnt_txr; b_und = cnt_und; b_ovr = cnt_ovr;
    rx_base = rx_got_q.size();
    spi_xfer(pol, pha, nbits);
    exp_txr = (k < cons) ? k : cons;
    chk({tag, " tx_ready"}, cnt_txr - b_txr, exp_txr);
    chk({tag, " underrun"}, cnt_und - b_und, cons - exp_txr);
    chk({tag, " busy_on"}, busy_before, 1'b1);
    chk({tag, " busy_off"}, busy_after, 1'b0);
    chk({tag, " oe_off"}, oe_after, 1'b0);
    for (int i = 0; i < n_full; i++) begin
      e = (i < k) ? tx_words_q[i] : '0;
      if (lsb_mode) e = bitrev(e);
      chk({tag, " miso"}, miso_words_q[i], e);
    end
    if (rdy) begin
      for (int i = 0; i < n_full; i++) exp_q.push_back(mosi_words_q[i]);
      chk({tag, " rx_count"}, rx_got_q.size() - rx_base, n_full);
      for (int i = 0; i < n_full; i++) begin
        e = exp_q.pop_front();
        chk({tag, " rx_word"}, (rx_base + i < rx_got_q.size()) ? rx_got_q[rx_base + i] : 32'hdead_beef, e);
      end
      chk({tag, " overrun"}, cnt_ovr - b_ovr, 0);
      chk({tag, " rx_valid"}, bus.rx_valid, 1'b0);
    end else if (n_full > 0) begin
      exp_ovr = n_full - 1 + (prior_valid ? 1 : 0);
      chk({tag, " overrun"}, cnt_ovr - b_ovr, exp_ovr);
      chk({tag, " rx_valid"}, bus.rx_valid, 1'b1);
      chk({tag, " rx_data"}, bus.rx_data, mosi_words_q[n_full-1]);
    end
    tx_words_q.delete();
    mosi_words_q.delete();
  endtask

  initial begin
    int nw;
    rst = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0;
    sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    bus.rx_ready = 1'b1;
    wait_cyc(4);
    chk("rst miso", miso, 1'b0);
    chk("rst miso_oe", miso_oe, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst rx_valid", bus.rx_valid, 1'b0);
    chk("rst rx_data", bus.rx_data, 0);
    chk("rst tx_ready", bus.tx_ready, 1'b0);
    chk("rst state", dbg_state, 1'b0);
    rst = 1'b0;
    wait_cyc(4);

    // mode 0: tx 0xA5, master 0x3C
    tx_words_q.push_back(8'hA5);
    mosi_words_q.push_back(8'h3C);
    run_xfer("m0", 1'b0, 1'b0, W, 1'b1);

    // mode 3: two back-to-back words
    tx_words_q.push_back(8'h12); tx_words_q.push_back(8'h34);
    mosi_words_q.push_back(8'hF0); mosi_words_q.push_back(8'h0F);
    run_xfer("m3", 1'b1, 1'b1, 2 * W, 1'b1);

    // mode 1: no TX data at all
    mosi_words_q.push_back(8'h5A); mosi_words_q.push_back(8'hC3);
    run_xfer("m1", 1'b0, 1'b1, 2 * W, 1'b1);

    // mode 2: consumer stalled, second word overruns
    mosi_words_q.push_back(8'h11); mosi_words_q.push_back(8'h22);
    run_xfer("m2", 1'b1, 1'b0, 2 * W, 1'b0);

    // reset in the middle of a transfer while rx_valid is held
    @(negedge sysclk);
    cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
    cs_n = 1'b0;
    wait_cyc(6);
    chk("midrst busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(posedge sysclk);
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst miso_oe", miso_oe, 1'b0);
    chk("midrst rx_valid", bus.rx_valid, 1'b0);
    chk("midrst rx_data", bus.rx_data, 0);
    @(negedge sysclk);
    rst = 1'b0; cs_n = 1'b1;
    wait_cyc(10);

    // disabled engine ignores CS
    enable = 1'b0; cs_n = 1'b0;
    wait_cyc(8);
    chk("disabled busy", busy, 1'b0);
    cs_n = 1'b1; enable = 1'b1;
    wait_cyc(8);

    // CS abort after 5 bits, then a full word
    tx_words_q.push_back(8'h77);
    mosi_words_q.push_back(8'hFF);
    run_xfer("abort", 1'b0, 1'b0, 5, 1'b1);
    tx_words_q.push_back(8'h3E);
    mosi_words_q.push_back(8'h81);
    run_xfer("after_abort", 1'b0, 1'b0, W, 1'b1);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    lsb_mode = 1'b1;
    tx_words_q.push_back(8'h01);
    mosi_words_q.push_back(8'h01);
    run_xfer("lsb", 1'b0, 1'b0, W, 1'b1);
    lsb_mode = 1'b0;
`endif

    // randomized transfers
    for (int t = 0; t < 12; t++) begin
      nw = $urandom_range(1, 3);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      lsb_mode = 1'($urandom_range(0, 1));
`endif
      for (int i = 0; i < nw; i++) mosi_words_q.push_back(W'($urandom));
      for (int i = 0; i < $urandom_range(0, nw + 1); i++) tx_words_q.push_back(W'($urandom));
      run_xfer("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nw * W, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
